regfile_wb_ctrl: RTL

Write-back and hazard controller that sits in front of the 32x64 integer register file and initiates all of its writes. It merges results from the single-cycle ALU and the multi-cycle LSU onto the single regfile write port. It keeps a per-register busy scoreboard so the issue stage stalls on RAW/WAW hazards. It drives w_ena/w_addr/w_data from registers, one cycle after a result is accepted.

---
 rtl/regfile_wb_ctrl_pkg.sv | 14 +
 rtl/regfile_wb_ctrl_wb_result_fifo.sv | 46 ++++
 rtl/regfile_wb_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared types and constants for the register-file write-back controller.
// Holds the write-back entry layout that the LSU holding FIFO stores.
package regfile_wb_ctrl_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned XLEN      = 64;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_entry;

endpackage

// File: rtl/regfile_wb_ctrl_wb_result_fifo.sv
// Small holding FIFO for LSU results waiting for the register-file write port.
// The pointers carry an extra wrap bit so that full and empty can be told apart.
module wb_result_fifo
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_push,
    input  wb_entry i_data,
    input  logic    i_pop,
    output wb_entry o_head,
    output logic    o_full,
    output logic    o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    wb_entry     r_mem [DEPTH];

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_head  = r_mem[r_rptr[AW-1:0]];

    // Push is gated by the pre-pop full flag, matching the ready given upstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push && !o_full)
                r_wptr <= r_wptr + 1'b1;
            if (i_pop && !o_empty)
                r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !o_full)
            r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back arbiter and busy scoreboard in front of the 32x64 register file.
// Optional issue-time forwarding from the write port is enabled by WB_BYPASS_EN.
module regfile_wb_ctrl #(
    parameter int unsigned XLEN          = regfile_wb_ctrl_pkg::XLEN,
    parameter int unsigned LSU_BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      iss_rs1,
    input  logic            iss_rs1_en,
    input  logic [4:0]      iss_rs2,
    input  logic            iss_rs2_en,
    output logic            iss_ready,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    output logic            w_ena,
    output logic [4:0]      w_addr,
    output logic [XLEN-1:0] w_data,
    output logic            byp_rs1_hit,
    output logic            byp_rs2_hit,
    output logic            err_unexp
);

    import regfile_wb_ctrl_pkg::*;

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_next;

    wb_entry   w_fifo_in;
    wb_entry   w_fifo_head;
    logic      w_fifo_full;
    logic      w_fifo_empty;
    logic      w_fifo_push;
    logic      w_fifo_pop;

    logic      w_alu_live;
    logic      w_lsu_acc;
    logic      w_lsu_live;
    logic      w_lsu_direct;
    logic      w_sel_valid;
    logic [4:0]      w_sel_rd;
    logic [XLEN-1:0] w_sel_data;

    logic      w_rs1_busy;
    logic      w_rs2_busy;
    logic      w_rd_busy;
    logic      w_issue;
    logic      w_unexp;

    // rd==0 results are accepted but never compete for the write port.
    assign w_alu_live   = alu_valid && (alu_rd != '0);
    assign w_lsu_acc    = lsu_valid && !w_fifo_full;
    assign w_lsu_live   = w_lsu_acc && (lsu_rd != '0);
    assign w_lsu_direct = w_lsu_live && !w_alu_live && w_fifo_empty;
    assign w_fifo_push  = w_lsu_live && !w_lsu_direct;
    assign w_fifo_pop   = !w_alu_live && !w_fifo_empty;
    assign lsu_ready    = !w_fifo_full;

    assign w_fifo_in.rd   = lsu_rd;
    assign w_fifo_in.data = lsu_data;

    wb_result_fifo #(
        .DEPTH (LSU_BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_fifo_push),
        .i_data  (w_fifo_in),
        .i_pop   (w_fifo_pop),
        .o_head  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_rd    = '0;
        w_sel_data  = '0;
        if (w_alu_live) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = alu_rd;
            w_sel_data  = alu_data;
        end else if (!w_fifo_empty) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = w_fifo_head.rd;
            w_sel_data  = w_fifo_head.data;
        end else if (w_lsu_direct) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = lsu_rd;
            w_sel_data  = lsu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_ena  <= 1'b0;
            w_addr <= '0;
            w_data <= '0;
        end else begin
            w_ena <= w_sel_valid;
            if (w_sel_valid) begin
                w_addr <= w_sel_rd;
                w_data <= w_sel_data;
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign byp_rs1_hit = iss_rs1_en && w_ena && (w_addr == iss_rs1) && (iss_rs1 != '0);
    assign byp_rs2_hit = iss_rs2_en && w_ena && (w_addr == iss_rs2) && (iss_rs2 != '0);
    assign w_rs1_busy  = iss_rs1_en && r_busy[iss_rs1] && !byp_rs1_hit;
    assign w_rs2_busy  = iss_rs2_en && r_busy[iss_rs2] && !byp_rs2_hit;
`else
    assign byp_rs1_hit = 1'b0;
    assign byp_rs2_hit = 1'b0;
    assign w_rs1_busy  = iss_rs1_en && r_busy[iss_rs1];
    assign w_rs2_busy  = iss_rs2_en && r_busy[iss_rs2];
`endif

    assign w_rd_busy = (iss_rd != '0) && r_busy[iss_rd];
    assign iss_ready = !w_rs1_busy && !w_rs2_busy && !w_rd_busy;
    assign w_issue   = iss_valid && iss_ready;

    // Clear precedes set; the WAW stall keeps them on different registers.
    always_comb begin
        w_busy_next = r_busy;
        if (w_ena)
            w_busy_next[w_addr] = 1'b0;
        if (w_issue && (iss_rd != '0))
            w_busy_next[iss_rd] = 1'b1;
        w_busy_next[0] = 1'b0;
    end

    assign w_unexp = (w_alu_live && !r_busy[alu_rd]) || (w_lsu_live && !r_busy[lsu_rd]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy    <= '0;
            err_unexp <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            if (w_unexp)
                err_unexp <= 1'b1;
        end
    end

endmodule
